// File: rtl/controlador_ataque.sv
// ---------------------------------------------------------------------------
// controlador_ataque
//
// Attack controller for a one-player battleship game on a 5x7 LED matrix.
// The player places ships with switches and locks them with "iniciar". The
// player then fires shots by choosing a column and row and pressing
// "confirmar_ataque". Each accepted shot is shown blinking for a while. The
// game ends in victory when every ship cell is hit. It ends in defeat when
// the shots run out.
//
// Ports
//   clock                           single divided clock (381 Hz)
//   reset_n                         synchronous active-low reset
//   ligado                          power switch, 0 forces the block off
//   iniciar                         one-cycle pulse: lock placement / new game
//   confirmar_ataque                one-cycle pulse: submit the shot
//   ataque_coluna, ataque_linha     target column (0..4) and row (0..6)
//   colunaN_posicionamento          ship map input, bit r = row r
//   colunaN_saida                   frame handed to the matrix scanner
//   acerto, erro, invalido          one-cycle shot result pulses
//   vitoria, derrota                game result levels, high in FIM
//   tentativas_restantes            shots left in the current game
//   estado                          current FSM state encoding
//
// Maps are kept flattened as 35-bit vectors: bit (col*7 + row), so
// coluna1 (column 0) sits in the low seven bits.
// ---------------------------------------------------------------------------
module controlador_ataque #(
  parameter int MAX_TENTATIVAS  = 20,
  parameter int PISCA_CICLOS    = 190,
  parameter int FEEDBACK_PISCAS = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ligado,
  input  logic       iniciar,
  input  logic       confirmar_ataque,
  input  logic [2:0] ataque_coluna,
  input  logic [2:0] ataque_linha,
  input  logic [6:0] coluna1_posicionamento,
  input  logic [6:0] coluna2_posicionamento,
  input  logic [6:0] coluna3_posicionamento,
  input  logic [6:0] coluna4_posicionamento,
  input  logic [6:0] coluna5_posicionamento,
  output logic [6:0] coluna1_saida,
  output logic [6:0] coluna2_saida,
  output logic [6:0] coluna3_saida,
  output logic [6:0] coluna4_saida,
  output logic [6:0] coluna5_saida,
  output logic       acerto,
  output logic       erro,
  output logic       invalido,
  output logic       vitoria,
  output logic       derrota,
  output logic [4:0] tentativas_restantes,
  output logic [2:0] estado
);

  localparam int FB_TOTAL = 2 * FEEDBACK_PISCAS * PISCA_CICLOS;
  localparam int PW       = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;
  localparam int FBW      = $clog2(FB_TOTAL + 1);

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    POSICIONAR = 3'd1,
    ATACAR     = 3'd2,
    VERIFICAR  = 3'd3,
    FEEDBACK   = 3'd4,
    FIM        = 3'd5
  } estado_t;

  estado_t estado_q, estado_d;

  logic [34:0]    navios_q, navios_d;
  logic [34:0]    acertos_q, acertos_d;
  logic [34:0]    erros_q, erros_d;
  logic [4:0]     tent_q, tent_d;
  logic [2:0]     col_q, col_d;
  logic [2:0]     lin_q, lin_d;
  logic [PW-1:0]  pisca_cnt_q, pisca_cnt_d;
  logic           fase_q, fase_d;
  logic [FBW-1:0] fb_cnt_q, fb_cnt_d;
  logic           acerto_q, acerto_d;
  logic           erro_q, erro_d;
  logic           invalido_q, invalido_d;
  logic           vitoria_q, vitoria_d;
  logic           derrota_q, derrota_d;

  logic [34:0] mapa_vivo;
  logic [5:0]  indice;
  logic        coord_ok;
  logic [34:0] mascara;
  logic        ja_usado;
  logic        tiro_invalido;
  logic        acertou;
  logic        fb_fim;
  logic        fim_vitoria;
  logic [34:0] quadro;

  // Shot decoding. The target is turned into a one-hot mask so that an
  // out-of-range coordinate never indexes outside the 35-bit maps; an
  // invalid coordinate simply yields an empty mask.
  always_comb begin
    mapa_vivo = {coluna5_posicionamento, coluna4_posicionamento,
                 coluna3_posicionamento, coluna2_posicionamento,
                 coluna1_posicionamento};
    indice        = ({3'b000, col_q} * 6'd7) + {3'b000, lin_q};
    coord_ok      = (col_q <= 3'd4) && (lin_q <= 3'd6);
    mascara       = coord_ok ? (35'd1 << indice) : '0;
    ja_usado      = ((acertos_q | erros_q) & mascara) != '0;
    tiro_invalido = !coord_ok || ja_usado;
    acertou       = (navios_q & mascara) != '0;
    fb_fim        = (fb_cnt_q == FBW'(FB_TOTAL - 1));
    fim_vitoria   = (acertos_q == navios_q);
  end

  // State register. Switching the power off behaves exactly like a reset.
  always_ff @(posedge clock) begin
    if (!reset_n || !ligado) begin
      estado_q <= DESLIGADO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic. Placement needs a non-empty map. A verified shot
  // goes back to ATACAR when it is rejected. Otherwise the shot goes to
  // FEEDBACK, and the end of FEEDBACK decides victory first, then defeat.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      DESLIGADO:  if (ligado) estado_d = POSICIONAR;
      POSICIONAR: if (iniciar && (mapa_vivo != '0)) estado_d = ATACAR;
      ATACAR:     if (confirmar_ataque) estado_d = VERIFICAR;
      VERIFICAR:  estado_d = tiro_invalido ? ATACAR : FEEDBACK;
      FEEDBACK: begin
        if (fb_fim) begin
          if (fim_vitoria)          estado_d = FIM;
          else if (tent_q == 5'd0)  estado_d = FIM;
          else                      estado_d = ATACAR;
        end
      end
      FIM:        if (iniciar) estado_d = POSICIONAR;
      default:    estado_d = DESLIGADO;
    endcase
    if (!ligado) estado_d = DESLIGADO;
  end

  // Datapath next values: the maps, the shot counter, the latched target,
  // the blink timer and the registered result pulses and levels. The
  // result pulses default low, so each one lasts a single cycle.
  always_comb begin
    navios_d    = navios_q;
    acertos_d   = acertos_q;
    erros_d     = erros_q;
    tent_d      = tent_q;
    col_d       = col_q;
    lin_d       = lin_q;
    pisca_cnt_d = pisca_cnt_q;
    fase_d      = fase_q;
    fb_cnt_d    = '0;
    acerto_d    = 1'b0;
    erro_d      = 1'b0;
    invalido_d  = 1'b0;
    vitoria_d   = vitoria_q;
    derrota_d   = derrota_q;

    // The blink phase restarts when a shot enters FEEDBACK. This makes
    // every feedback animation start the same way.
    if (estado_q == DESLIGADO) begin
      pisca_cnt_d = '0;
      fase_d      = 1'b0;
    end else if ((estado_q == VERIFICAR) && !tiro_invalido) begin
      pisca_cnt_d = '0;
      fase_d      = 1'b0;
    end else if (pisca_cnt_q == PW'(PISCA_CICLOS - 1)) begin
      pisca_cnt_d = '0;
      fase_d      = !fase_q;
    end else begin
      pisca_cnt_d = pisca_cnt_q + PW'(1);
    end

    case (estado_q)
      POSICIONAR: begin
        if (iniciar) begin
          if (mapa_vivo != '0) begin
            navios_d  = mapa_vivo;
            acertos_d = '0;
            erros_d   = '0;
            tent_d    = 5'(MAX_TENTATIVAS);
          end else begin
            invalido_d = 1'b1;
          end
        end
      end
      ATACAR: begin
        if (confirmar_ataque) begin
          col_d = ataque_coluna;
          lin_d = ataque_linha;
        end
      end
      VERIFICAR: begin
        if (tiro_invalido) begin
          invalido_d = 1'b1;
        end else if (acertou) begin
          acertos_d = acertos_q | mascara;
          acerto_d  = 1'b1;
          tent_d    = tent_q - 5'd1;
        end else begin
          erros_d = erros_q | mascara;
          erro_d  = 1'b1;
          tent_d  = tent_q - 5'd1;
        end
      end
      FEEDBACK: begin
        if (fb_fim) begin
          if (fim_vitoria)         vitoria_d = 1'b1;
          else if (tent_q == 5'd0) derrota_d = 1'b1;
        end else begin
          fb_cnt_d = fb_cnt_q + FBW'(1);
        end
      end
      FIM: begin
        if (iniciar) begin
          vitoria_d = 1'b0;
          derrota_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. They share the reset and power-off clear with the
  // state register, so DESLIGADO always starts from a clean slate.
  always_ff @(posedge clock) begin
    if (!reset_n || !ligado) begin
      navios_q    <= '0;
      acertos_q   <= '0;
      erros_q     <= '0;
      tent_q      <= '0;
      col_q       <= '0;
      lin_q       <= '0;
      pisca_cnt_q <= '0;
      fase_q      <= 1'b0;
      fb_cnt_q    <= '0;
      acerto_q    <= 1'b0;
      erro_q      <= 1'b0;
      invalido_q  <= 1'b0;
      vitoria_q   <= 1'b0;
      derrota_q   <= 1'b0;
    end else begin
      navios_q    <= navios_d;
      acertos_q   <= acertos_d;
      erros_q     <= erros_d;
      tent_q      <= tent_d;
      col_q       <= col_d;
      lin_q       <= lin_d;
      pisca_cnt_q <= pisca_cnt_d;
      fase_q      <= fase_d;
      fb_cnt_q    <= fb_cnt_d;
      acerto_q    <= acerto_d;
      erro_q      <= erro_d;
      invalido_q  <= invalido_d;
      vitoria_q   <= vitoria_d;
      derrota_q   <= derrota_d;
    end
  end

  // Output logic: build the frame for the matrix from the current state.
  // In ATACAR, hits are solid and misses blink. In FEEDBACK, the target
  // cell shows the inverted phase, so it lights up right away.
  always_comb begin
    quadro = '0;
    case (estado_q)
      POSICIONAR: quadro = mapa_vivo;
      ATACAR, VERIFICAR: quadro = acertos_q | (erros_q & {35{fase_q}});
      FEEDBACK: quadro = ((acertos_q | (erros_q & {35{fase_q}})) & ~mascara)
                         | (mascara & {35{!fase_q}});
      FIM: begin
        if (vitoria_q)      quadro = acertos_q;
        else if (derrota_q) quadro = navios_q & {35{fase_q}};
      end
      default: quadro = '0;
    endcase

    coluna1_saida        = quadro[6:0];
    coluna2_saida        = quadro[13:7];
    coluna3_saida        = quadro[20:14];
    coluna4_saida        = quadro[27:21];
    coluna5_saida        = quadro[34:28];
    acerto               = acerto_q;
    erro                 = erro_q;
    invalido             = invalido_q;
    vitoria              = vitoria_q;
    derrota              = derrota_q;
    tentativas_restantes = tent_q;
    estado               = estado_q;
  end

endmodule

// File: tb/tb_controlador_ataque.sv
// ---------------------------------------------------------------------------
// tb_controlador_ataque
//
// Self-checking bench for controlador_ataque with short timing parameters
// (PISCA_CICLOS=2, FEEDBACK_PISCAS=1, MAX_TENTATIVAS=3). Each shot pushes its
// expected result code {acerto,erro,invalido} into a queue. The result is
// popped and compared when the DUT raises a result pulse. Inputs change one
// time unit after the rising edge, and outputs are read at that same point.
// ---------------------------------------------------------------------------
module tb_controlador_ataque;

  localparam int P = 2;
  localparam int F = 1;
  localparam int M = 3;

  logic       clock;
  logic       reset_n;
  logic       ligado;
  logic       iniciar;
  logic       confirmar_ataque;
  logic [2:0] ataque_coluna;
  logic [2:0] ataque_linha;
  logic [6:0] c1p, c2p, c3p, c4p, c5p;
  logic [6:0] c1s, c2s, c3s, c4s, c5s;
  logic       acerto, erro, invalido, vitoria, derrota;
  logic [4:0] tentativas_restantes;
  logic [2:0] estado;

  int total = 0;
  int bad   = 0;
  logic [2:0] sb[$];

  controlador_ataque #(
    .MAX_TENTATIVAS(M),
    .PISCA_CICLOS(P),
    .FEEDBACK_PISCAS(F)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .ligado(ligado),
    .iniciar(iniciar),
    .confirmar_ataque(confirmar_ataque),
    .ataque_coluna(ataque_coluna),
    .ataque_linha(ataque_linha),
    .coluna1_posicionamento(c1p),
    .coluna2_posicionamento(c2p),
    .coluna3_posicionamento(c3p),
    .coluna4_posicionamento(c4p),
    .coluna5_posicionamento(c5p),
    .coluna1_saida(c1s),
    .coluna2_saida(c2s),
    .coluna3_saida(c3s),
    .coluna4_saida(c4s),
    .coluna5_saida(c5s),
    .acerto(acerto),
    .erro(erro),
    .invalido(invalido),
    .vitoria(vitoria),
    .derrota(derrota),
    .tentativas_restantes(tentativas_restantes),
    .estado(estado)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle one time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_map(input logic [6:0] a, b, c, d, e);
    c1p = a; c2p = b; c3p = c; c4p = d; c5p = e;
  endtask

  task automatic pulse_iniciar;
    iniciar = 1'b1;
    step(1);
    iniciar = 1'b0;
  endtask

  // Drive one confirm pulse and record the result it should produce.
  task automatic fire(input logic [2:0] col, input logic [2:0] row, input logic [2:0] expct);
    sb.push_back(expct);
    ataque_coluna    = col;
    ataque_linha     = row;
    confirmar_ataque = 1'b1;
    step(1);
    confirmar_ataque = 1'b0;
  endtask

  // Wait (bounded) for a result pulse and pop the matching expectation.
  // cyc is the number of edges waited, or -1 when nothing arrived.
  task automatic take_result(output logic [2:0] obs, output logic [2:0] expct, output int cyc);
    cyc = 0;
    obs = {acerto, erro, invalido};
    while (obs == 3'b000 && cyc < 8) begin
      step(1);
      cyc++;
      obs = {acerto, erro, invalido};
    end
    if (obs == 3'b000) cyc = -1;
    if (sb.size() != 0) expct = sb.pop_front();
    else                expct = 3'b000;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ligado = 1'b0; iniciar = 1'b0; confirmar_ataque = 1'b0;
    ataque_coluna = '0; ataque_linha = '0;
    set_map('0, '0, '0, '0, '0);
    step(2);
    total++; if (estado !== 3'd0) begin bad++; $display("[TB] FAIL reset_estado got=%0d want=0", estado); end
    total++; if ({c5s, c4s, c3s, c2s, c1s} !== 35'd0) begin bad++; $display("[TB] FAIL reset_saida got=%h want=0", {c5s, c4s, c3s, c2s, c1s}); end
    total++; if ({acerto, erro, invalido, vitoria, derrota} !== 5'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b want=00000", {acerto, erro, invalido, vitoria, derrota}); end
    total++; if (tentativas_restantes !== 5'd0) begin bad++; $display("[TB] FAIL reset_tent got=%0d want=0", tentativas_restantes); end
    reset_n = 1'b1; ligado = 1'b1;
    step(1);
    total++; if (estado !== 3'd1) begin bad++; $display("[TB] FAIL power_on got=%0d want=1", estado); end
  endtask

  task automatic test_empty_map;
    logic [2:0] obs, expct;
    int cyc;
    set_map('0, '0, '0, '0, '0);
    sb.push_back(3'b001);
    pulse_iniciar();
    take_result(obs, expct, cyc);
    total++; if (obs !== expct) begin bad++; $display("[TB] FAIL empty_map_result got=%b want=%b", obs, expct); end
    total++; if (cyc !== 0) begin bad++; $display("[TB] FAIL empty_map_latency got=%0d want=0", cyc); end
    total++; if (estado !== 3'd1) begin bad++; $display("[TB] FAIL empty_map_estado got=%0d want=1", estado); end
    // A confirm in POSICIONAR must be ignored.
    confirmar_ataque = 1'b1; step(1); confirmar_ataque = 1'b0; step(1);
    total++; if ({estado, acerto, erro, invalido} !== {3'd1, 3'b000}) begin bad++; $display("[TB] FAIL confirm_ignored got=%b want=001000", {estado, acerto, erro, invalido}); end
  endtask

  task automatic test_victory;
    logic [2:0] obs, expct;
    int cyc;
    logic blink [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    set_map(7'b0000001, '0, '0, '0, '0);
    step(1);
    total++; if ({c5s, c4s, c3s, c2s, c1s} !== 35'd1) begin bad++; $display("[TB] FAIL live_map got=%h want=1", {c5s, c4s, c3s, c2s, c1s}); end
    pulse_iniciar();
    total++; if (estado !== 3'd2) begin bad++; $display("[TB] FAIL start_estado got=%0d want=2", estado); end
    total++; if (tentativas_restantes !== 5'(M)) begin bad++; $display("[TB] FAIL start_tent got=%0d want=%0d", tentativas_restantes, M); end
    fire(3'd0, 3'd0, 3'b100);
    take_result(obs, expct, cyc);
    total++; if (obs !== expct) begin bad++; $display("[TB] FAIL hit_result got=%b want=%b", obs, expct); end
    total++; if (cyc !== 1) begin bad++; $display("[TB] FAIL hit_latency got=%0d want=1", cyc); end
    total++; if (tentativas_restantes !== 5'd2) begin bad++; $display("[TB] FAIL hit_tent got=%0d want=2", tentativas_restantes); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1);
      total++; if ({estado, c1s[0]} !== {3'd4, blink[k]}) begin bad++; $display("[TB] FAIL feedback_blink%0d got=%b want=%b", k, {estado, c1s[0]}, {3'd4, blink[k]}); end
    end
    step(1);
    total++; if ({estado, vitoria, derrota} !== {3'd5, 2'b10}) begin bad++; $display("[TB] FAIL victory got=%b want=10110", {estado, vitoria, derrota}); end
    total++; if (c1s !== 7'b0000001) begin bad++; $display("[TB] FAIL victory_display got=%b want=0000001", c1s); end
    pulse_iniciar();
    total++; if ({estado, vitoria} !== {3'd1, 1'b0}) begin bad++; $display("[TB] FAIL restart got=%b want=0010", {estado, vitoria}); end
  endtask

  task automatic test_defeat;
    logic [2:0] obs, expct;
    int cyc;
    logic blink [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    pulse_iniciar();
    pulse_iniciar();
    total++; if ({estado, tentativas_restantes} !== {3'd2, 5'd3}) begin bad++; $display("[TB] FAIL iniciar_ignored got=%b want=01000011", {estado, tentativas_restantes}); end
    fire(3'd5, 3'd0, 3'b001);
    take_result(obs, expct, cyc);
    total++; if (obs !== expct) begin bad++; $display("[TB] FAIL col5_result got=%b want=%b", obs, expct); end
    total++; if ({estado, tentativas_restantes} !== {3'd2, 5'd3}) begin bad++; $display("[TB] FAIL col5_state got=%b want=01000011", {estado, tentativas_restantes}); end
    fire(3'd0, 3'd7, 3'b001);
    take_result(obs, expct, cyc);
    total++; if (obs !== expct) begin bad++; $display("[TB] FAIL row7_result got=%b want=%b", obs, expct); end
    fire(3'd1, 3'd0, 3'b010);
    take_result(obs, expct, cyc);
    total++; if (obs !== expct) begin bad++; $display("[TB] FAIL miss1_result got=%b want=%b", obs, expct); end
    total++; if (tentativas_restantes !== 5'd2) begin bad++; $display("[TB] FAIL miss1_tent got=%0d want=2", tentativas_restantes); end
    step(3);
    total++; if (estado !== 3'd4) begin bad++; $display("[TB] FAIL feedback_len got=%0d want=4", estado); end
    step(1);
    total++; if (estado !== 3'd2) begin bad++; $display("[TB] FAIL feedback_exit got=%0d want=2", estado); end
    fire(3'd1, 3'd0, 3'b001);
    take_result(obs, expct, cyc);
    total++; if (obs !== expct) begin bad++; $display("[TB] FAIL repeat_result got=%b want=%b", obs, expct); end
    total++; if (tentativas_restantes !== 5'd2) begin bad++; $display("[TB] FAIL repeat_tent got=%0d want=2", tentativas_restantes); end
    fire(3'd2, 3'd0, 3'b010);
    take_result(obs, expct, cyc);
    total++; if ({obs, tentativas_restantes} !== {expct, 5'd1}) begin bad++; $display("[TB] FAIL miss2 got=%b want=%b", {obs, tentativas_restantes}, {expct, 5'd1}); end
    step(4);
    fire(3'd3, 3'd0, 3'b010);
    take_result(obs, expct, cyc);
    total++; if ({obs, tentativas_restantes} !== {expct, 5'd0}) begin bad++; $display("[TB] FAIL miss3 got=%b want=%b", {obs, tentativas_restantes}, {expct, 5'd0}); end
    step(4);
    total++; if ({estado, vitoria, derrota} !== {3'd5, 2'b01}) begin bad++; $display("[TB] FAIL defeat got=%b want=10101", {estado, vitoria, derrota}); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1);
      total++; if (c1s[0] !== blink[k]) begin bad++; $display("[TB] FAIL defeat_blink%0d got=%b want=%b", k, c1s[0], blink[k]); end
    end
  endtask

  task automatic test_locked_map_and_reset;
    logic [2:0] obs, expct;
    int cyc;
    pulse_iniciar();
    set_map(7'b0000001, '0, '0, '0, '0);
    pulse_iniciar();
    set_map('0, '0, 7'h7f, '0, '0);
    step(1);
    fire(3'd0, 3'd0, 3'b100);
    take_result(obs, expct, cyc);
    total++; if (obs !== expct) begin bad++; $display("[TB] FAIL locked_map got=%b want=%b", obs, expct); end
    step(1);
    reset_n = 1'b0;
    step(1);
    total++; if (estado !== 3'd0) begin bad++; $display("[TB] FAIL fb_reset_estado got=%0d want=0", estado); end
    total++; if ({c5s, c4s, c3s, c2s, c1s, acerto, erro, invalido, vitoria, derrota, tentativas_restantes} !== 45'd0) begin bad++; $display("[TB] FAIL fb_reset_outputs got=%h want=0", {c5s, c4s, c3s, c2s, c1s, acerto, erro, invalido, vitoria, derrota, tentativas_restantes}); end
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_power_off;
    set_map(7'b0000001, '0, '0, '0, '0);
    total++; if (estado !== 3'd1) begin bad++; $display("[TB] FAIL off_pre got=%0d want=1", estado); end
    pulse_iniciar();
    ligado = 1'b0;
    step(1);
    total++; if ({estado, tentativas_restantes} !== {3'd0, 5'd0}) begin bad++; $display("[TB] FAIL power_off got=%b want=0", {estado, tentativas_restantes}); end
    ligado = 1'b1;
    step(1);
    total++; if (estado !== 3'd1) begin bad++; $display("[TB] FAIL power_back got=%0d want=1", estado); end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_empty_map();
    test_victory();
    test_defeat();
    test_locked_map_and_reset();
    test_power_off();
    total++; if (sb.size() !== 0) begin bad++; $display("[TB] FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
